counter_cmd_seq: RTL
====================

# counter_cmd_seq

Command sequencer that sits directly upstream of the 4-bit loadable up/down counter and drives its `load`, `data` and `updown` inputs. It accepts LOAD / UP / DOWN / HOLD commands over a valid/ready handshake and expands each one into per-cycle counter controls. It keeps a shadow copy of the expected counter value, so the counter never drifts while idle; the bench uses that shadow as its reference model.

## Interface
- `W`, 4: counter data width.
- `LEN_W`, 8: width of the command cycle-count field.

- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset; also resets the downstream counter.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command; high only in IDLE.
- `cmd_op`  in  2: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_data`  in  W: load value; used by LOAD only.
- `cmd_len`  in  LEN_W: cycles to run for UP/DOWN/HOLD; ignored for LOAD.
- `load`  out  1: to counter `load`.
- `data`  out  W: to counter `data`.
- `updown`  out  1: to counter `updown`; 1 means up.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse after a command completes.
- `shadow`  out  W: expected counter value.

## Operation
- Registers: `state` (IDLE/RUN), `op`, `ld_val`, `rem` (LEN_W bits), `shadow` (W bits), `done`.
- Outputs `load/data/updown/cmd_ready/busy` are combinational from these registers only. They never depend on `cmd_*`.
- IDLE:
  - `load`=1, `data`=`shadow`, `updown`=0. This holds the counter at the shadow value.
  - `cmd_ready`=1.
  - Handshake fires when `cmd_valid && cmd_ready` at a posedge. On fire: `op`←`cmd_op`, `ld_val`←`cmd_data`, and `state`←RUN.
  - `rem`←1 for LOAD; `rem`←max(`cmd_len`,1) for the others.
  - If `cmd_len`==0 for UP/DOWN, `op` is latched as HOLD (one-cycle no-op).
- RUN, per cycle:
  - LOAD: `load`=1, `data`=`ld_val`; `shadow`←`ld_val`.
  - UP: `load`=0, `updown`=1; `shadow`←`shadow`+1.
  - DOWN: `load`=0, `updown`=0; `shadow`←`shadow`−1.
  - HOLD: `load`=1, `data`=`shadow`; `shadow` unchanged.
  - In RUN, `data`=`shadow` whenever `load`=0 (value is a don't-care to the counter, but fixed for determinism).
  - `rem`←`rem`−1 each cycle. At the edge where `rem`==1: `state`←IDLE and `done`←1.
- `done` is set only at that edge and cleared on every other edge.
- Arithmetic is modulo 2^W: 0xF+1=0x0 and 0x0−1=0xF with W=4. No saturation and no flags.
- `cmd_valid` with `cmd_ready`=0 is not consumed. The producer must hold the command stable until accepted.
- Reset mid-RUN: the command is aborted and not reported. No `done` pulse is produced.

## Timing
- After a `rst` edge: `state`=IDLE, `shadow`=0, `rem`=0, `done`=0, `op`=HOLD, `ld_val`=0.
  - Resulting outputs: `load`=1, `data`=0, `updown`=0, `cmd_ready`=1, `busy`=0, `done`=0, `shadow`=0.
- `cmd_*` is ignored in any cycle where `rst` is high.
- Accept at edge k. RUN covers cycles k..k+N−1, where N=`rem`.
- The counter value after edge k+N equals `shadow` after edge k+N.
- `done` is high during cycle k+N (IDLE again).
- Throughput: one command per N+1 cycles. `cmd_ready` is low during RUN, so there is a mandatory idle cycle between commands.
- Invariant, checked every cycle after reset: counter `data_out` == `shadow`.

## Test plan
- Reset: assert `rst` 2 cycles -> `shadow`=0, `load`=1, `data`=0, `cmd_ready`=1, `busy`=0, `done`=0, counter=0.
- LOAD 0x9 -> 1 RUN cycle with `load`=1, `data`=9; then `shadow`=9, counter=9, `done` pulses once; counter stays 9 for 5 further idle cycles.
- LOAD 0xE, then UP len 3 -> counter sequence E,F,0,1; `shadow`=1; `done` one cycle after the 3rd RUN cycle.
- From 0, DOWN len 2 -> counter 0,F,E (wrap); then HOLD len 5 -> counter stays E for 5 cycles; `busy` high for exactly 5 cycles.
- UP len 0 and DOWN len 0 -> each takes exactly 1 RUN cycle; counter unchanged; `done` pulses.
- Hold `cmd_valid` with UP len 4 during an active command -> no acceptance until IDLE. Then assert `rst` after 2 UP cycles -> `shadow`=0, counter=0, no `done`, `cmd_ready`=1 on the next cycle.

Source files
------------

// File: rtl/counter_cmd_seq.sv
// Command sequencer for a 4-bit loadable up/down counter: expands LOAD/UP/DOWN/HOLD
// commands into per-cycle load/data/updown controls while tracking a shadow of the count.
module counter_cmd_seq #(
  parameter int W     = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [W-1:0]     cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             load,
  output logic [W-1:0]     data,
  output logic             updown,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     shadow
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0]       OP_LOAD = 2'b00;
  localparam logic [1:0]       OP_UP   = 2'b01;
  localparam logic [1:0]       OP_DOWN = 2'b10;
  localparam logic [1:0]       OP_HOLD = 2'b11;
  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);
  localparam logic [W-1:0]     ONE_W   = W'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     ld_val_q, ld_val_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_HOLD;
      ld_val_q <= '0;
      rem_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ld_val_q <= ld_val_d;
      rem_q    <= rem_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  // Counter controls come from registers only; in IDLE the counter is pinned to shadow.
  always_comb begin
    load      = 1'b1;
    data      = shadow_q;
    updown    = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    if (state_q == S_IDLE) begin
      cmd_ready = 1'b1;
    end else begin
      busy = 1'b1;
      case (op_q)
        OP_LOAD: data = ld_val_q;
        OP_UP: begin
          load   = 1'b0;
          updown = 1'b1;
        end
        OP_DOWN: load = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ld_val_d = ld_val_q;
    rem_d    = rem_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        state_d  = S_RUN;
        ld_val_d = cmd_data;
        op_d     = cmd_op;
        if (cmd_op == OP_LOAD || cmd_len == '0) begin
          rem_d = REM_ONE;
        end else begin
          rem_d = cmd_len;
        end
        // A zero-length UP/DOWN degenerates to a single no-op cycle.
        if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_len == '0) begin
          op_d = OP_HOLD;
        end
      end
    end else begin
      case (op_q)
        OP_LOAD: shadow_d = ld_val_q;
        OP_UP:   shadow_d = shadow_q + ONE_W;
        OP_DOWN: shadow_d = shadow_q - ONE_W;
        default: ;
      endcase
      rem_d = rem_q - REM_ONE;
      if (rem_q == REM_ONE) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign done   = done_q;
  assign shadow = shadow_q;

endmodule
